// File: rtl/sr_cmd_pkg.sv
// Shared types and default parameters for the sr_ff command generator.
package sr_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE_S = 2'd1,
      PULSE_R = 2'd2,
      GAP     = 2'd3
   } state_t;

   localparam int DEB_CYCLES_D = 4;
   localparam int PULSE_LEN_D  = 2;
   localparam int GAP_LEN_D    = 1;

   // Larger of two integers, used to size the shared pulse/gap counter.
   function automatic int max2(input int a, input int b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser, stability-counter debounce and registered
// rising-edge detector for one raw request line.
module sync_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic req
);

   localparam int CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          deb_r;
   logic          deb_d_r;
   logic [CW-1:0] cnt_r;
   logic          req_r;

   // Synchronise, accept a level only after DEB_CYCLES stable cycles, then flag its rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         deb_r   <= 1'b0;
         deb_d_r <= 1'b0;
         cnt_r   <= '0;
         req_r   <= 1'b0;
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
         if (sync2_r != deb_r) begin
            if (cnt_r == CNT_LAST) begin
               deb_r <= sync2_r;
               cnt_r <= '0;
            end else begin
               cnt_r <= cnt_r + CW'(1);
            end
         end else begin
            cnt_r <= '0;
         end
         deb_d_r <= deb_r;
         req_r   <= deb_r & ~deb_d_r;
      end
   end

   assign req = req_r;

endmodule

// File: rtl/sr_cmd_gen.sv
// Command generator for sr_ff: debounced set/clear requests are arbitrated
// into registered, mutually exclusive S/R pulses separated by idle gaps.
module sr_cmd_gen
   import sr_cmd_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_D,
   parameter int PULSE_LEN  = PULSE_LEN_D,
   parameter int GAP_LEN    = GAP_LEN_D
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_req_raw,
   input  logic clr_req_raw,
   input  logic q_fb,
   output logic S,
   output logic R,
   output logic busy,
   output logic conflict
);

   localparam int PW = $clog2(max2(PULSE_LEN, GAP_LEN)) + 1;
   localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN - 1);
   localparam logic [PW-1:0] GAP_LOAD   = PW'(GAP_LEN - 1);

   logic          set_req;
   logic          clr_req;
   state_t        state_r, state_nxt;
   logic [PW-1:0] pcnt_r, pcnt_nxt;
   logic          pend_set_r, pend_set_nxt;
   logic          pend_clr_r, pend_clr_nxt;
   logic          conflict_evt_r, conflict_nxt;
   logic          cand_set, cand_clr, run_start;
   logic          s_r, r_r, busy_r, conflict_r;

   sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (set_req_raw),
      .req   (set_req)
   );

   sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (clr_req_raw),
      .req   (clr_req)
   );

   // Next-state logic: pulse/gap timing, pending capture and the start check.
   always_comb begin
      state_nxt    = state_r;
      pcnt_nxt     = pcnt_r;
      pend_set_nxt = pend_set_r;
      pend_clr_nxt = pend_clr_r;
      conflict_nxt = 1'b0;
      cand_set     = 1'b0;
      cand_clr     = 1'b0;
      run_start    = 1'b0;
      case (state_r)
         IDLE: begin
            cand_set  = set_req;
            cand_clr  = clr_req;
            run_start = 1'b1;
         end
         PULSE_S, PULSE_R: begin
            pend_set_nxt = pend_set_r | set_req;
            pend_clr_nxt = pend_clr_r | clr_req;
            if (pcnt_r == '0) begin
               state_nxt = GAP;
               pcnt_nxt  = GAP_LOAD;
            end else begin
               pcnt_nxt = pcnt_r - PW'(1);
            end
         end
         GAP: begin
            if (pcnt_r == '0) begin
               // A request landing on the exit cycle is folded in rather than lost.
               cand_set     = pend_set_r | set_req;
               cand_clr     = pend_clr_r | clr_req;
               pend_set_nxt = 1'b0;
               pend_clr_nxt = 1'b0;
               state_nxt    = IDLE;
               run_start    = 1'b1;
            end else begin
               pend_set_nxt = pend_set_r | set_req;
               pend_clr_nxt = pend_clr_r | clr_req;
               pcnt_nxt     = pcnt_r - PW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (run_start) begin
         if (cand_set && cand_clr) begin
            conflict_nxt = 1'b1;
         end else if (cand_set && !q_fb) begin
            state_nxt = PULSE_S;
            pcnt_nxt  = PULSE_LOAD;
         end else if (cand_clr && q_fb) begin
            state_nxt = PULSE_R;
            pcnt_nxt  = PULSE_LOAD;
         end else begin
            // Redundant or absent command: nothing issued.
            conflict_nxt = 1'b0;
         end
      end else begin
         conflict_nxt = 1'b0;
      end
   end

   // FSM state, counter, pending flags and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         pcnt_r         <= '0;
         pend_set_r     <= 1'b0;
         pend_clr_r     <= 1'b0;
         conflict_evt_r <= 1'b0;
         s_r            <= 1'b0;
         r_r            <= 1'b0;
         busy_r         <= 1'b0;
         conflict_r     <= 1'b0;
      end else begin
         state_r        <= state_nxt;
         pcnt_r         <= pcnt_nxt;
         pend_set_r     <= pend_set_nxt;
         pend_clr_r     <= pend_clr_nxt;
         conflict_evt_r <= conflict_nxt;
         s_r            <= (state_r == PULSE_S);
         r_r            <= (state_r == PULSE_R);
         busy_r         <= (state_r != IDLE);
         conflict_r     <= conflict_evt_r;
      end
   end

   assign S        = s_r;
   assign R        = r_r;
   assign busy     = busy_r;
   assign conflict = conflict_r;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench: sr_cmd_gen driving a behavioural sr_ff with Q fed back.
module tb_sr_cmd_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic set_raw = 1'b0;
   logic clr_raw = 1'b0;
   logic q;
   logic s, r, busy, conflict;

   int errors = 0;
   int checks = 0;
   int mutex_hits = 0;

   logic [31:0] s_vec, r_vec, b_vec, c_vec, q_vec;

   always #5 clk = ~clk;

   sr_cmd_gen dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .set_req_raw (set_raw),
      .clr_req_raw (clr_raw),
      .q_fb        (q),
      .S           (s),
      .R           (r),
      .busy        (busy),
      .conflict    (conflict)
   );

   // Behavioural sr_ff downstream of the generator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else if (s) begin
         q <= 1'b1;
      end else if (r) begin
         q <= 1'b0;
      end else begin
         q <= q;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      set_raw = 1'b0;
      clr_raw = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
   endtask

   // Bit e of sp/cp is the raw level held before edge e; outputs sampled 1 after edge e.
   task automatic run_log(input int n, input logic [31:0] sp, input logic [31:0] cp);
      s_vec = '0; r_vec = '0; b_vec = '0; c_vec = '0; q_vec = '0;
      for (int e = 0; e < n; e++) begin
         set_raw = sp[e];
         clr_raw = cp[e];
         @(posedge clk);
         #1;
         s_vec[e] = s;
         r_vec[e] = r;
         b_vec[e] = busy;
         c_vec[e] = conflict;
         q_vec[e] = q;
         if (s && r) mutex_hits++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset with set request held high.
      rst_n   = 1'b0;
      set_raw = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_outs", {28'd0, s, r, busy, conflict}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_log(16, 32'hFFFF_FFFF, 32'h0);
      check_eq("rst_S_edge7", {31'd0, s_vec[7]}, 32'd0);
      check_eq("rst_S_vec", s_vec, 32'h0000_0300);
      check_eq("rst_Q_end", {31'd0, q_vec[15]}, 32'd1);

      // Clean set request with Q=0.
      do_reset();
      run_log(20, 32'h0000_0FFF, 32'h0);
      check_eq("set_S", s_vec, 32'h0000_0300);
      check_eq("set_R", r_vec, 32'h0);
      check_eq("set_busy", b_vec, 32'h0000_0700);
      check_eq("set_conflict", c_vec, 32'h0);
      check_eq("set_Q", q_vec, 32'h000F_FE00);

      // Bouncing set input never settles long enough.
      do_reset();
      run_log(24, 32'h0000_00E7, 32'h0);
      check_eq("bounce_S", s_vec, 32'h0);
      check_eq("bounce_busy", b_vec, 32'h0);

      // Simultaneous opposite requests are discarded.
      do_reset();
      run_log(16, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_eq("both_conflict", c_vec, 32'h0000_0100);
      check_eq("both_S", s_vec, 32'h0);
      check_eq("both_R", r_vec, 32'h0);
      check_eq("both_Q", q_vec, 32'h0);

      // Clear request landing during PULSE_S is queued behind the gap.
      do_reset();
      run_log(20, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      check_eq("seq_S", s_vec, 32'h0000_0300);
      check_eq("seq_R", r_vec, 32'h0000_1800);
      check_eq("seq_busy", b_vec, 32'h0000_3F00);
      check_eq("seq_conflict", c_vec, 32'h0);
      check_eq("seq_Q", q_vec, 32'h0000_0E00);

      // Redundant set while Q=1.
      do_reset();
      run_log(20, 32'h0000_0FFF, 32'h0);
      check_eq("redund_Q_pre", {31'd0, q_vec[19]}, 32'd1);
      run_log(20, 32'hFFFF_FFFF, 32'h0);
      check_eq("redund_S", s_vec, 32'h0);
      check_eq("redund_busy", b_vec, 32'h0);
      check_eq("redund_conflict", c_vec, 32'h0);
      check_eq("redund_Q", q_vec, 32'h000F_FFFF);

      // Reset asserted in the middle of PULSE_R.
      do_reset();
      run_log(16, 32'h0000_0FFF, 32'h0);
      run_log(10, 32'h0, 32'h0);
      run_log(9, 32'h0, 32'hFFFF_FFFF);
      check_eq("abort_R_on", {31'd0, r_vec[8]}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("abort_R_off", {31'd0, r}, 32'd0);
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_S", {31'd0, s}, 32'd0);
      clr_raw = 1'b0;
      #20;
      rst_n = 1'b1;

      check_eq("mutex", mutex_hits, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
- Upstream command stage for sr_ff: turns two raw, bouncy request lines (set / clear) into clean, registered, mutually exclusive S and R pulses that drive sr_ff directly on the same clk.
- Synchronises and debounces each input, edge-detects, and arbitrates through a small FSM.
- Never presents S=R=1 downstream.
- Uses Q fed back from sr_ff to drop redundant commands.

Parameters:
- DEB_CYCLES, 4: consecutive stable synced cycles required to accept a level change; legal range ≥2.
- PULSE_LEN, 2: cycles S or R is held high per command; legal range ≥1.
- GAP_LEN, 1: idle cycles forced after each pulse before the next pulse; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- set_req_raw  in  1  raw set request (asynchronous, may bounce).
- clr_req_raw  in  1  raw clear request (asynchronous, may bounce).
- q_fb  in  1  Q from the downstream sr_ff.
- S  out  1  set command to sr_ff (registered).
- R  out  1  reset command to sr_ff (registered).
- busy  out  1  high whenever FSM is not IDLE.
- conflict  out  1  one-cycle pulse when simultaneous opposite commands are discarded.

Behaviour:
- Reset: async on rst_n=0.
  - S=R=busy=conflict=0.
  - Sync flops, debounced levels, counters and pending flags all cleared to 0.
  - FSM goes to IDLE.
  - Reset mid-pulse drops S/R immediately.
- Sync: 2-flop synchroniser per input.
- Debounce, per channel:
  - cnt increments each cycle sync≠deb; it clears when sync=deb.
  - When sync≠deb and cnt=DEB_CYCLES-1: deb<=sync, cnt<=0.
- Edge: req pulses one cycle in the cycle after deb rises (registered). Falling deb generates nothing.
  - A raw input held high through reset release yields a request; this is the intended behaviour.
- Latency: raw stable high before edge 0 → S (or R) high after edge 4+DEB_CYCLES (8 with defaults).
- FSM states: IDLE, PULSE_S, PULSE_R, GAP.
- Start check (used in IDLE and at GAP exit, against the candidate set):
  - req_s & req_r both present → discard both; conflict=1 next cycle; stay/return IDLE.
  - set candidate with q_fb=1, or clear candidate with q_fb=0 → discard silently; no pulse, no conflict.
  - Otherwise go to PULSE_S or PULSE_R; S or R is registered high from the next edge.
- IDLE: candidates are the req_s / req_r pulses of that cycle.
- PULSE_x: hold S (or R) for exactly PULSE_LEN cycles, then go to GAP with S=R=0.
- GAP: GAP_LEN cycles with S=R=0; at exit, run the start check on the pending flags, clear the flags, and go to IDLE if nothing is issued.
- Pending flags: a req arriving outside IDLE sets pend_s or pend_r (one-deep; repeats merge). The flags are the candidates at GAP exit.
- Mutual exclusion: S and R are never both 1 in any cycle, including across reset release.
- Pulse counter: width $clog2(max(PULSE_LEN, GAP_LEN))+1. It saturates never; it is reloaded on each state entry.

Decomposition:
- Package sr_cmd_pkg:
  - typedef enum logic [1:0] for state_t {IDLE, PULSE_S, PULSE_R, GAP}.
  - Default constants DEB_CYCLES_D=4, PULSE_LEN_D=2, GAP_LEN_D=1.
- Sub-module sync_debounce: synchroniser + debounce counter + rising-edge pulse, parameterised by DEB_CYCLES.
  - Instantiated twice (set, clear).
  - Top holds only FSM, pending flags and output registers.

Test Plan (defaults; bench instantiates sr_cmd_gen → sr_ff, q_fb=Q):
- Reset with set_req_raw=1 held: during rst_n=0, S=R=busy=conflict=0. After release, S rises at edge 8, Q=1 afterwards.
- set_req_raw 0→1 held 12 cycles, Q=0: S=1 at edges 8–9, R=0 throughout, busy=1 for edges 8–10, then busy=0, Q=1.
- Bounce: set_req_raw high 3 cycles, low 2, high 3, low → no S pulse, busy stays 0.
- Both raw inputs rise together and are held: conflict=1 for one cycle at edge 8, S=R=0, Q unchanged.
- Set request, then clr_req_raw rises so that req_r lands during PULSE_S: S pulses 2 cycles, 1-cycle gap, then R pulses 2 cycles. Final Q=0, no conflict.
- Redundant and abort cases:
  - Q=1 and a new set request → no S pulse, no conflict.
  - rst_n asserted mid PULSE_R → R falls without waiting for a clock, busy=0.
